// File: rtl/cpu_types_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : cpu_types_pkg
// Brief    : Shared CPU/RAM types plus the RAM arbiter state encoding.
// Revision : 1.0
// ============================================================================
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        XFER1 = 2'd1,
        XFER2 = 2'd2,
        GAP   = 2'd3
    } arb_state_t;

    // Byte offset of the second word of a two-word block.
    localparam word_t c_WORD_STEP = 32'd4;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : rr_pick
// Brief    : Combinational round-robin picker; first request after ptr wins.
// Revision : 1.0
// ============================================================================
module rr_pick
    import cpu_types_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IW   = idx_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] onehot,
    output logic [IW-1:0]   idx,
    output logic            valid
);

    logic [IW-1:0] w_cand;

    // Scan ptr+1, ptr+2, ... wrapping; ptr itself is visited last.
    always_comb begin
        onehot = '0;
        idx    = '0;
        valid  = 1'b0;
        w_cand = '0;
        for (int i = 1; i <= NREQ; i++) begin
            w_cand = IW'((int'(ptr) + i) % NREQ);
            if (!valid && req[w_cand]) begin
                valid          = 1'b1;
                idx            = w_cand;
                onehot[w_cand] = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ram_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : ram_arbiter
// Brief    : Round-robin arbiter giving one requester at a time the shared RAM.
// Revision : 1.0
// ============================================================================
module ram_arbiter
    import cpu_types_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 15
) (
    input  logic            CLK,
    input  logic            nRST,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] wen,
    input  logic [NREQ-1:0] blk,
    input  word_t           addr  [NREQ],
    input  word_t           store [NREQ],
    output logic [NREQ-1:0] gnt,
    output logic [NREQ-1:0] rwait,
    output word_t           load,
    output logic            err,
    output logic            ramREN,
    output logic            ramWEN,
    output word_t           ramaddr,
    output word_t           ramstore,
    input  word_t           ramload,
    input  ramstate_t       ramstate
);

    localparam int IW = idx_width(NREQ);
    localparam int CW = $clog2(TIMEOUT + 1);

    arb_state_t      r_state;
    arb_state_t      w_next_state;
    logic [IW-1:0]   r_ptr;
    logic [IW-1:0]   r_owner;
    logic [NREQ-1:0] r_gnt;
    logic [CW-1:0]   r_cnt;

    logic [NREQ-1:0] w_pick_onehot;
    logic [IW-1:0]   w_pick_idx;
    logic            w_pick_valid;

    logic w_in_xfer;
    logic w_access;
    logic w_timeout;
    logic w_withdraw;
    logic w_abort;

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr_pick (
        .req    (req),
        .ptr    (r_ptr),
        .onehot (w_pick_onehot),
        .idx    (w_pick_idx),
        .valid  (w_pick_valid)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= IDLE;
            r_ptr   <= IW'(NREQ - 1);
            r_owner <= '0;
            r_gnt   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            if ((r_state == IDLE) && w_pick_valid) begin
                r_ptr   <= w_pick_idx;
                r_owner <= w_pick_idx;
                r_gnt   <= w_pick_onehot;
            end
            if (w_next_state != r_state) begin
                r_cnt <= '0;
            end else if (w_in_xfer && !w_access) begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    // A completing word always beats a timeout or a withdrawal in the same cycle.
    always_comb begin
        w_in_xfer    = (r_state == XFER1) || (r_state == XFER2);
        w_access     = (ramstate == ACCESS);
        w_timeout    = !w_access && (r_cnt == CW'(TIMEOUT - 1));
        w_withdraw   = !w_access && !req[r_owner];
        w_abort      = w_in_xfer && ((ramstate == ERROR) || w_timeout || w_withdraw);
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_pick_valid) w_next_state = XFER1;
            end
            XFER1: begin
                if (w_abort)       w_next_state = GAP;
                else if (w_access) w_next_state = blk[r_owner] ? XFER2 : GAP;
            end
            XFER2: begin
                if (w_abort || w_access) w_next_state = GAP;
            end
            GAP: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_comb begin
        gnt      = '0;
        rwait    = '1;
        load     = '0;
        err      = 1'b0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        if (w_in_xfer) begin
            gnt            = r_gnt;
            rwait[r_owner] = !w_access;
            load           = ramload;
            err            = w_abort;
            ramREN         = !wen[r_owner];
            ramWEN         = wen[r_owner];
            ramstore       = store[r_owner];
            ramaddr        = (r_state == XFER2) ? (addr[r_owner] + c_WORD_STEP)
                                                : addr[r_owner];
        end
    end

endmodule
`default_nettype wire

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameters SHALL be: NREQ, default 4, number of requesters; TIMEOUT, default 15, max cycles per word awaiting ACCESS.
REQ-002 Ports SHALL be:
- CLK  in  1  clock, rising edge.
- nRST  in  1  reset, asynchronous, active-low.
- req  in  NREQ  per-requester access request, level.
- wen  in  NREQ  1=write, 0=read.
- blk  in  NREQ  1=two-word block (addr, addr+4); 0=single word.
- addr  in  NREQ x word_t  word address per requester.
- store  in  NREQ x word_t  write data per requester.
- gnt  out  NREQ  one-hot current owner.
- rwait  out  NREQ  0 = current word complete this cycle.
- load  out  word_t  read data, shared by all requesters.
- err  out  1  one-cycle abort pulse.
- ramREN, ramWEN  out  1  RAM strobes.
- ramaddr, ramstore  out  word_t  RAM address/data.
- ramload  in  word_t  RAM read data.
- ramstate  in  ramstate_t  FREE/BUSY/ACCESS/ERROR.

Function
REQ-003 FSM states SHALL be IDLE, XFER1, XFER2, GAP.
REQ-004 IDLE with any req high SHALL register winner into gnt and go XFER1 next cycle; no req -> stay IDLE.
REQ-005 Winner SHALL be first req set searching from (ptr+1) mod NREQ upward, wrapping; ptr SHALL load winner index at grant.
REQ-006 XFER1 SHALL drive ramaddr=addr[g], ramREN=~wen[g], ramWEN=wen[g], ramstore=store[g]; other requesters rwait=1.
REQ-007 XFER2 SHALL drive ramaddr=addr[g]+4, store/strobes as XFER1; address add modulo 2^32.
REQ-008 In XFER1/XFER2, rwait[g]=(ramstate!=ACCESS) combinationally; load=ramload whenever gnt nonzero, else 0.
REQ-009 XFER1 on ACCESS SHALL go XFER2 if blk[g], else GAP; XFER2 on ACCESS SHALL go GAP.
REQ-010 GAP SHALL last exactly one cycle with gnt=0, RAM strobes 0, then IDLE; no back-to-back grants.
REQ-011 Per-word counter SHALL clear on each state entry and increment per non-ACCESS cycle in XFER1/XFER2; reaching TIMEOUT SHALL abort.
REQ-012 ramstate==ERROR in XFER1/XFER2 SHALL abort.
REQ-013 req[g] falling during XFER1/XFER2 SHALL abort unless ramstate==ACCESS that cycle (completion wins).
REQ-014 Abort SHALL: pulse err for one cycle, keep rwait[g]=1, go GAP; ptr retains aborted index.
REQ-015 wen/blk/addr/store of the owner SHALL be sampled combinationally; holding them stable while req high is the requester's duty.
REQ-016 gnt SHALL never have more than one bit set; ramREN and ramWEN SHALL never both be 1.

Reset
REQ-017 nRST low SHALL immediately force: state IDLE, ptr=NREQ-1 (requester 0 first), gnt=0, rwait all 1, err=0, counter=0, ramREN=ramWEN=0, ramaddr=ramstore=load=0.
REQ-018 Reset mid-transfer SHALL drop the transfer with no err pulse; the requester re-requests.

Structure
REQ-019 word_t and ramstate_t SHALL come from cpu_types_pkg; arb_state_t enum SHALL be added there.
REQ-020 One sub-module rr_pick (combinational priority rotator: req, ptr -> one-hot, index, valid) SHALL be used.
REQ-021 Sequential logic SHALL be in one always_ff block on CLK/negedge nRST; all outputs from always_comb.

Verification
REQ-022 Single read: req[2]=1, wen=0, blk=0, addr=0x100, ACCESS after 2 cycles -> gnt=0100 at cycle 1, ramaddr=0x100, rwait[2]=0 at cycle 3, GAP, IDLE.
REQ-023 Block write: req[1], wen=1, blk=1, addr=0x200 -> ramaddr 0x200 then 0x204, ramWEN=1 both words, rwait[1] low twice.
REQ-024 Round-robin: all four req held -> grant order 0,1,2,3,0 with one GAP cycle between grants.
REQ-025 Timeout: ramstate held BUSY -> abort after 15 cycles, err pulse, rwait stays 1, next grant skips to ptr+1.
REQ-026 Withdrawal/error: drop req[0] mid-XFER1 -> err, GAP; ramstate=ERROR in XFER2 -> err, GAP.
REQ-027 Reset mid-XFER2 -> all outputs at reset values same cycle, ptr=3, no err.
